// File: rtl/imm_pkg.sv
// Shared definitions for the pipelined immediate generator: format codes,
// handshake state encoding and default datapath width.
package imm_pkg;

   localparam int unsigned XLEN_DEFAULT = 32;
   localparam int unsigned INSTR_W      = 25;   // instruction bits [31:7]

   typedef logic [2:0] immsrc_t;

   localparam immsrc_t IMMSRC_I = 3'b000;
   localparam immsrc_t IMMSRC_S = 3'b001;
   localparam immsrc_t IMMSRC_B = 3'b010;
   localparam immsrc_t IMMSRC_J = 3'b011;
   localparam immsrc_t IMMSRC_U = 3'b100;

   // Occupancy of the output register / skid register pair.
   // Bit 1 is "main register valid", bit 0 is "skid register valid".
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b10,
      ST_FULL  = 2'b11
   } state_t;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Upstream and downstream handshake bundle of the immediate generator.
// slave is the generator side, master is the fetch/execute (or bench) side.
interface imm_gen_pipe_if import imm_pkg::*; #(
   parameter int unsigned XLEN = XLEN_DEFAULT
);
   logic                 in_valid;
   logic                 in_ready;
   logic [INSTR_W-1:0]   instr;
   immsrc_t              immsrc;
   logic                 out_valid;
   logic                 out_ready;
   logic [XLEN-1:0]      immext;
   immsrc_t              out_immsrc;
   logic                 illegal;

   modport master (
      output in_valid, instr, immsrc, out_ready,
      input  in_ready, out_valid, immext, out_immsrc, illegal
   );

   modport slave (
      input  in_valid, instr, immsrc, out_ready,
      output in_ready, out_valid, immext, out_immsrc, illegal
   );
endinterface

// File: rtl/imm_format_dec.sv
// Combinational RV32I/RV64I immediate decoder: extracts the I/S/B/J/U
// immediate from instruction bits [31:7] and sign-extends it to XLEN.
// Unknown format codes yield zero and raise illegal_o.
module imm_format_dec import imm_pkg::*; #(
   parameter int unsigned XLEN = XLEN_DEFAULT
) (
   input  logic [INSTR_W-1:0] instr_i,
   input  immsrc_t            immsrc_i,
   output logic [XLEN-1:0]    imm_o,
   output logic               illegal_o
);

   // Keep the original instruction bit numbering so the field slices read
   // exactly like the ISA manual.
   logic [31:7] f_s;
   logic [31:0] imm32_s;

   assign f_s = instr_i;

   // Select and assemble the 32-bit immediate for the requested format.
   always_comb begin
      imm32_s   = 32'd0;
      illegal_o = 1'b0;
      case (immsrc_i)
         IMMSRC_I: imm32_s = {{20{f_s[31]}}, f_s[31:20]};
         IMMSRC_S: imm32_s = {{20{f_s[31]}}, f_s[31:25], f_s[11:7]};
         IMMSRC_B: imm32_s = {{19{f_s[31]}}, f_s[31], f_s[7], f_s[30:25], f_s[11:8], 1'b0};
         IMMSRC_J: imm32_s = {{11{f_s[31]}}, f_s[31], f_s[19:12], f_s[20], f_s[30:21], 1'b0};
         IMMSRC_U: imm32_s = {f_s[31:12], 12'd0};
         default: begin
            imm32_s   = 32'd0;
            illegal_o = 1'b1;
         end
      endcase
   end

   // Every format is signed from bit 31, so widening to XLEN is a plain
   // sign extension of the 32-bit result (a no-op when XLEN is 32).
   assign imm_o = XLEN'(signed'(imm32_s));

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator. The decode happens ahead of the output
// register so immext is a pure flop output. With SKID_EN=1 a second entry
// register absorbs one extra transfer, letting in_ready be registered with
// no combinational path from out_ready. With SKID_EN=0 there is a single
// register stage and in_ready = !out_valid || out_ready.
module imm_gen_pipe import imm_pkg::*; #(
   parameter int unsigned XLEN    = XLEN_DEFAULT,
   parameter bit          SKID_EN = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   imm_gen_pipe_if.slave bus
);

   logic [XLEN-1:0] dec_imm_s;
   logic            dec_ill_s;
   logic            in_ready_s;
   logic            accept_s;
   logic            emit_s;

   state_t          state_q,    state_d;
   logic            in_ready_q, in_ready_d;
   logic [XLEN-1:0] imm_q,      imm_d;
   immsrc_t         src_q,      src_d;
   logic            ill_q,      ill_d;
   logic [XLEN-1:0] skid_imm_q, skid_imm_d;
   immsrc_t         skid_src_q, skid_src_d;
   logic            skid_ill_q, skid_ill_d;

   imm_format_dec #(.XLEN(XLEN)) u_dec (
      .instr_i   (bus.instr),
      .immsrc_i  (bus.immsrc),
      .imm_o     (dec_imm_s),
      .illegal_o (dec_ill_s)
   );

   // Handshake qualifiers; flush blocks any accept in its cycle.
   always_comb begin
      in_ready_s = 1'b0;
      if (SKID_EN) begin
         in_ready_s = in_ready_q;
      end else begin
         in_ready_s = (state_q == ST_EMPTY) || bus.out_ready;
      end
      accept_s = bus.in_valid && in_ready_s && !flush;
      emit_s   = (state_q != ST_EMPTY) && bus.out_ready;
   end

   // Occupancy next state and entry register loads; flush wins over
   // accept and emit, and the skid entry always drains into main first.
   always_comb begin
      state_d    = state_q;
      imm_d      = imm_q;
      src_d      = src_q;
      ill_d      = ill_q;
      skid_imm_d = skid_imm_q;
      skid_src_d = skid_src_q;
      skid_ill_d = skid_ill_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept_s) begin
                  state_d = ST_ONE;
                  imm_d   = dec_imm_s;
                  src_d   = bus.immsrc;
                  ill_d   = dec_ill_s;
               end else begin
                  state_d = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (accept_s && emit_s) begin
                  state_d = ST_ONE;
                  imm_d   = dec_imm_s;
                  src_d   = bus.immsrc;
                  ill_d   = dec_ill_s;
               end else if (emit_s) begin
                  state_d = ST_EMPTY;
               end else if (accept_s && SKID_EN) begin
                  state_d    = ST_FULL;
                  skid_imm_d = dec_imm_s;
                  skid_src_d = bus.immsrc;
                  skid_ill_d = dec_ill_s;
               end else begin
                  state_d = ST_ONE;
               end
            end
            ST_FULL: begin
               if (emit_s) begin
                  state_d = ST_ONE;
                  imm_d   = skid_imm_q;
                  src_d   = skid_src_q;
                  ill_d   = skid_ill_q;
               end else begin
                  state_d = ST_FULL;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
      in_ready_d = (state_d != ST_FULL);
   end

   // Occupancy, registered in_ready and entry registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
         imm_q      <= '0;
         src_q      <= 3'd0;
         ill_q      <= 1'b0;
         skid_imm_q <= '0;
         skid_src_q <= 3'd0;
         skid_ill_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         imm_q      <= imm_d;
         src_q      <= src_d;
         ill_q      <= ill_d;
         skid_imm_q <= skid_imm_d;
         skid_src_q <= skid_src_d;
         skid_ill_q <= skid_ill_d;
      end
   end

   assign bus.in_ready   = in_ready_s;
   assign bus.out_valid  = (state_q != ST_EMPTY);
   assign bus.immext     = imm_q;
   assign bus.out_immsrc = src_q;
   assign bus.illegal    = ill_q;

endmodule
